dmem_access_ctrl: RTL and testbench

- Sequences the data-memory access for the load/store held in the EX/MEM pipeline register.
- Decodes the MEM-stage read/write control fields and drives a req/ack data-memory port with byte lanes.
- Formats load data (sign/zero extension) for the MEM/WB register.
- Asserts STALL to freeze PC, IF/ID, ID/EX and EX/MEM until the access retires.

---
 rtl/dmem_access_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: req/ack port with byte lanes, load formatting, pipeline stall.
// Optional DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses trap instead of being issued.
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] MEM_ALU_OUT,
  input  logic [31:0] MEM_REG_DATA2,
  input  logic [3:0]  MEM_DATA_MEM_READ,
  input  logic [2:0]  MEM_DATA_MEM_WRITE,
  output logic        STALL,
  output logic [31:0] LOAD_DATA,
  output logic        BUS_ERROR,
  output logic        MISALIGN,
  output logic        DM_REQ,
  output logic        DM_WE,
  output logic [31:0] DM_ADDR,
  output logic [31:0] DM_WDATA,
  output logic [3:0]  DM_BE,
  input  logic [31:0] DM_RDATA,
  input  logic        DM_ACK
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;
  typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_e;

  localparam bit               TimeoutEn   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       load_q, load_d;
  logic              berr_q, berr_d;
  logic              mis_q, mis_d;
  logic              ld_q, ld_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        lane_q, lane_d;

  logic              op_load, op_store, op_valid;
  logic [1:0]        lane;
  size_e             acc_size;
  logic [3:0]        acc_be;
  logic [31:0]       acc_wdata;
  logic              misaligned;
  logic              timeout_hit;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       rd_fmt;

  // Load has priority when both enables are set.
  assign op_load  = MEM_DATA_MEM_READ[3];
  assign op_store = MEM_DATA_MEM_WRITE[2] & ~op_load;
  assign op_valid = op_load | op_store;
  assign lane     = MEM_ALU_OUT[1:0];

  always_comb begin
    acc_size = SzWord;
    if (op_load) begin
      unique case (MEM_DATA_MEM_READ[2:0])
        3'b000, 3'b100: acc_size = SzByte;
        3'b001, 3'b101: acc_size = SzHalf;
        default:        acc_size = SzWord;
      endcase
    end else begin
      unique case (MEM_DATA_MEM_WRITE[1:0])
        2'b00:   acc_size = SzByte;
        2'b01:   acc_size = SzHalf;
        default: acc_size = SzWord;
      endcase
    end
  end

  always_comb begin
    acc_be    = 4'b1111;
    acc_wdata = MEM_REG_DATA2;
    unique case (acc_size)
      SzByte: begin
        acc_be    = 4'b0001 << lane;
        acc_wdata = {4{MEM_REG_DATA2[7:0]}};
      end
      SzHalf: begin
        acc_be    = lane[1] ? 4'b1100 : 4'b0011;
        acc_wdata = {2{MEM_REG_DATA2[15:0]}};
      end
      default: begin
        acc_be    = 4'b1111;
        acc_wdata = MEM_REG_DATA2;
      end
    endcase
    if (!op_store) acc_wdata = '0;
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misaligned = ((acc_size == SzHalf) & lane[0]) | ((acc_size == SzWord) & (|lane));
`else
  assign misaligned = 1'b0;
`endif

  assign timeout_hit = TimeoutEn && (cnt_q == TimeoutLast);

  // Load formatting uses the lane/funct3 latched when the request was issued.
  always_comb begin
    rd_byte = DM_RDATA[7:0];
    unique case (lane_q)
      2'd0: rd_byte = DM_RDATA[7:0];
      2'd1: rd_byte = DM_RDATA[15:8];
      2'd2: rd_byte = DM_RDATA[23:16];
      2'd3: rd_byte = DM_RDATA[31:24];
      default: rd_byte = DM_RDATA[7:0];
    endcase
    rd_half = lane_q[1] ? DM_RDATA[31:16] : DM_RDATA[15:0];
    unique case (f3_q)
      3'b000:  rd_fmt = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  rd_fmt = {24'b0, rd_byte};
      3'b001:  rd_fmt = {{16{rd_half[15]}}, rd_half};
      3'b101:  rd_fmt = {16'b0, rd_half};
      default: rd_fmt = DM_RDATA;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    load_d  = load_q;
    berr_d  = 1'b0;
    mis_d   = 1'b0;
    ld_d    = ld_q;
    f3_d    = f3_q;
    lane_d  = lane_q;
    unique case (state_q)
      StIdle: begin
        if (op_valid) begin
          if (misaligned) begin
            mis_d   = 1'b1;
            load_d  = '0;
            state_d = StDone;
          end else begin
            req_d   = 1'b1;
            we_d    = op_store;
            addr_d  = {MEM_ALU_OUT[31:2], 2'b00};
            wdata_d = acc_wdata;
            be_d    = acc_be;
            cnt_d   = '0;
            ld_d    = op_load;
            f3_d    = MEM_DATA_MEM_READ[2:0];
            lane_d  = lane;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (DM_ACK) begin
          req_d   = 1'b0;
          load_d  = ld_q ? rd_fmt : '0;
          state_d = StDone;
        end else if (timeout_hit) begin
          req_d   = 1'b0;
          load_d  = '0;
          berr_d  = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      load_q  <= '0;
      berr_q  <= 1'b0;
      mis_q   <= 1'b0;
      ld_q    <= 1'b0;
      f3_q    <= '0;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      load_q  <= load_d;
      berr_q  <= berr_d;
      mis_q   <= mis_d;
      ld_q    <= ld_d;
      f3_q    <= f3_d;
      lane_q  <= lane_d;
    end
  end

  // Stall is combinational so the upstream registers freeze in the issuing cycle.
  assign STALL     = RESET & (((state_q == StIdle) & op_valid) | (state_q == StWait));
  assign LOAD_DATA = load_q;
  assign BUS_ERROR = berr_q;
  assign MISALIGN  = mis_q;
  assign DM_REQ    = req_q;
  assign DM_WE     = we_q;
  assign DM_ADDR   = addr_q;
  assign DM_WDATA  = wdata_q;
  assign DM_BE     = be_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Randomized bench for dmem_access_ctrl with a transaction-level model and per-cycle compare.
module tb_dmem_access_ctrl;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] alu_out, reg_data2, dm_rdata;
  logic [3:0]  mem_read;
  logic [2:0]  mem_write;
  logic        dm_ack;
  logic        stall, bus_error, misalign, dm_req, dm_we;
  logic [31:0] load_data, dm_addr, dm_wdata;
  logic [3:0]  dm_be;

  dmem_access_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .CLK(clk), .RESET(rst_n), .MEM_ALU_OUT(alu_out), .MEM_REG_DATA2(reg_data2),
    .MEM_DATA_MEM_READ(mem_read), .MEM_DATA_MEM_WRITE(mem_write), .STALL(stall),
    .LOAD_DATA(load_data), .BUS_ERROR(bus_error), .MISALIGN(misalign), .DM_REQ(dm_req),
    .DM_WE(dm_we), .DM_ADDR(dm_addr), .DM_WDATA(dm_wdata), .DM_BE(dm_be),
    .DM_RDATA(dm_rdata), .DM_ACK(dm_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Expectations set by the stimulus, consumed by the compare process.
  bit          chk_en = 1'b0;
  bit          exp_stall, exp_req, exp_we, exp_done, exp_berr, exp_mis;
  logic [31:0] exp_addr, exp_wdata, exp_load;
  logic [3:0]  exp_be;

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", stall, exp_stall);
      check("dm_req", dm_req, exp_req);
      if (exp_req) begin
        check("dm_we", dm_we, exp_we);
        check("dm_addr", dm_addr, exp_addr);
        if (exp_we) begin
          check("dm_be", dm_be, exp_be);
          check("dm_wdata", dm_wdata, exp_wdata);
        end
      end
      check("load_data", load_data, exp_load);
      check("bus_error", bus_error, exp_done & exp_berr);
      check("misalign", misalign, exp_done & exp_mis);
    end
  end

  int stall_run = 0, last_stall = 0, req_run = 0, last_req = 0;
  always @(negedge clk) begin
    if (stall) stall_run <= stall_run + 1;
    else begin
      if (stall_run != 0) last_stall <= stall_run;
      stall_run <= 0;
    end
    if (dm_req) req_run <= req_run + 1;
    else begin
      if (req_run != 0) last_req <= req_run;
      req_run <= 0;
    end
  end

  logic        cap_req, cap_we, cap_berr, cap_mis;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;

  task automatic set_noop();
    mem_read  = {1'b0, 3'($urandom)};
    mem_write = {1'b0, 2'($urandom)};
    alu_out   = $urandom;
    reg_data2 = $urandom;
  endtask

  task automatic idle_cycle();
    set_noop();
    dm_ack    = ($urandom_range(0, 3) == 0);
    dm_rdata  = $urandom;
    exp_stall = 1'b0;
    exp_req   = 1'b0;
    exp_done  = 1'b0;
    @(posedge clk); #1;
    dm_ack = 1'b0;
  endtask

  // delay: ack in the delay-th wait cycle; 0 (or > TO) means no ack.
  task automatic run_op(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] rdata, input int delay);
    bit          is_load, is_store, trap, timed_out, signed_ld;
    int          nbytes, a, shift;
    logic [31:0] v, result;
    is_load  = rd[3];
    is_store = wr[2] && !is_load;
    a        = int'(addr[1:0]);
    if (is_load) nbytes = (rd[2:0] == 3'd0 || rd[2:0] == 3'd4) ? 1 :
                          (rd[2:0] == 3'd1 || rd[2:0] == 3'd5) ? 2 : 4;
    else         nbytes = (wr[1:0] == 2'd0) ? 1 : (wr[1:0] == 2'd1) ? 2 : 4;
`ifdef DMEM_MISALIGN_TRAP_EN
    trap = (nbytes == 2 && (a % 2) != 0) || (nbytes == 4 && a != 0);
`else
    trap = 1'b0;
`endif
    signed_ld = (rd[2] == 1'b0);
    shift = (nbytes == 1) ? 8 * a : (nbytes == 2) ? 16 * (a / 2) : 0;
    v = rdata >> shift;
    if (nbytes == 1) begin
      v = v & 32'hFF;
      if (signed_ld && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (nbytes == 2) begin
      v = v & 32'hFFFF;
      if (signed_ld && v >= 32'd32768) v = v | 32'hFFFF_0000;
    end
    result = is_load ? v : 32'd0;

    mem_read  = rd;
    mem_write = wr;
    alu_out   = addr;
    reg_data2 = data;
    dm_ack    = 1'b0;
    dm_rdata  = $urandom;
    exp_stall = 1'b1;
    exp_req   = 1'b0;
    exp_done  = 1'b0;
    @(posedge clk); #1;
    cap_req   = dm_req;
    cap_we    = dm_we;
    cap_addr  = dm_addr;
    cap_be    = dm_be;
    cap_wdata = dm_wdata;
    timed_out = 1'b0;
    if (!trap) begin
      exp_req   = 1'b1;
      exp_we    = is_store;
      exp_addr  = addr & 32'hFFFF_FFFC;
      exp_be    = (nbytes == 1) ? (4'b0001 << a) : (nbytes == 2) ? (4'b0011 << (a & 2)) : 4'hF;
      exp_wdata = (nbytes == 1) ? (data & 32'hFF) * 32'h0101_0101 :
                  (nbytes == 2) ? (data & 32'hFFFF) * 32'h0001_0001 : data;
      timed_out = 1'b1;
      for (int w = 0; w < int'(TO); w++) begin
        if (w == delay - 1) begin
          dm_ack   = 1'b1;
          dm_rdata = rdata;
        end else begin
          dm_ack   = 1'b0;
          dm_rdata = $urandom;
        end
        @(posedge clk); #1;
        if (dm_ack) begin
          dm_ack    = 1'b0;
          timed_out = 1'b0;
          break;
        end
      end
    end
    exp_stall = 1'b0;
    exp_req   = 1'b0;
    exp_done  = 1'b1;
    exp_berr  = timed_out;
    exp_mis   = trap;
    exp_load  = (trap || timed_out) ? 32'd0 : result;
    cap_berr  = bus_error;
    cap_mis   = misalign;
    @(posedge clk); #1;
    exp_done = 1'b0;
    set_noop();
  endtask

  initial begin
    rst_n     = 1'b1;
    dm_ack    = 1'b0;
    dm_rdata  = '0;
    mem_read  = 4'b1010;
    mem_write = 3'b100;
    alu_out   = 32'h1234_5678;
    reg_data2 = 32'hFFFF_FFFF;
    exp_load  = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_stall", stall, 1'b0);
    check("rst_req", dm_req, 1'b0);
    check("rst_we", dm_we, 1'b0);
    check("rst_addr", dm_addr, 32'h0);
    check("rst_wdata", dm_wdata, 32'h0);
    check("rst_be", dm_be, 4'h0);
    check("rst_load", load_data, 32'h0);
    check("rst_berr", bus_error, 1'b0);
    check("rst_mis", misalign, 1'b0);
    @(posedge clk); #1;
    check("rst_held_stall", stall, 1'b0);
    set_noop();
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_stall = 1'b0; exp_req = 1'b0; exp_done = 1'b0;
    chk_en = 1'b1;
    idle_cycle();

    // LB sign extension, ack in third wait cycle.
    run_op(4'b1000, 3'b000, 32'h0000_1002, 32'h0, 32'h00F3_0000, 3);
    check("lb_addr", cap_addr, 32'h0000_1000);
    check("lb_data", load_data, 32'hFFFF_FFF3);
    check("lb_stall_len", last_stall, 4);
    idle_cycle();

    // LHU upper half, ack in first wait cycle.
    run_op(4'b1101, 3'b000, 32'h0000_2006, 32'h0, 32'h8001_ABCD, 1);
    check("lhu_data", load_data, 32'h0000_8001);
    check("lhu_stall_len", last_stall, 2);

    // SB into lane 3.
    run_op(4'b0000, 3'b100, 32'h0000_3003, 32'h1234_5678, 32'h0, 2);
    check("sb_we", cap_we, 1'b1);
    check("sb_be", cap_be, 4'b1000);
    check("sb_wdata", cap_wdata, 32'h7878_7878);
    check("sb_addr", cap_addr, 32'h0000_3000);
    check("sb_load", load_data, 32'h0);

    // Timeout, then a normal access.
    run_op(4'b1010, 3'b000, 32'h0000_5000, 32'h0, 32'hDEAD_BEEF, 0);
    check("to_req_len", last_req, TO);
    check("to_berr", cap_berr, 1'b1);
    check("to_load", load_data, 32'h0);
    run_op(4'b1010, 3'b000, 32'h0000_5004, 32'h0, 32'hCAFE_BABE, 2);
    check("post_to_load", load_data, 32'hCAFE_BABE);

    // Misaligned word.
    run_op(4'b1010, 3'b000, 32'h0000_4001, 32'h0, 32'h1122_3344, 1);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("mis_req", cap_req, 1'b0);
    check("mis_pulse", cap_mis, 1'b1);
    check("mis_stall_len", last_stall, 1);
    check("mis_load", load_data, 32'h0);
`else
    check("mis_req", cap_req, 1'b1);
    check("mis_addr", cap_addr, 32'h0000_4000);
    check("mis_load", load_data, 32'h1122_3344);
    check("mis_stall_len", last_stall, 2);
`endif

    for (int i = 0; i < 300; i++) begin
      logic [3:0]  rd;
      logic [2:0]  wr;
      int          kind;
      kind = $urandom_range(0, 2);
      rd = {kind != 1, 3'($urandom)};
      wr = {kind != 0, 2'($urandom)};
      run_op(rd, wr, $urandom, $urandom, $urandom, $urandom_range(0, 5));
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end

    // Reset in the middle of a wait.
    mem_read  = 4'b1010;
    mem_write = 3'b000;
    alu_out   = 32'h0000_6000;
    dm_ack    = 1'b0;
    chk_en    = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_req_before", dm_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_req", dm_req, 1'b0);
    check("mid_rst_stall", stall, 1'b0);
    check("mid_rst_load", load_data, 32'h0);
    set_noop();
    @(posedge clk); #1;
    rst_n    = 1'b1;
    exp_load = '0;
    chk_en   = 1'b1;
    for (int i = 0; i < 4; i++) idle_cycle();
    run_op(4'b1100, 3'b000, 32'h0000_7001, 32'h0, 32'h0000_8000, 1);
    check("post_rst_lbu", load_data, 32'h0000_0080);
    idle_cycle();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
